ramp_decoder: RTL and testbench

//  Receive side of the 8-bit step counter: samples the counter's qout stream every clk,

---
 rtl/ramp_decoder_pkg.sv | 52 +++++
 rtl/ramp_decoder_window_timer.sv | 33 +++
 rtl/ramp_decoder.sv | 168 ++++++++++++++++
 tb/tb_ramp_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ramp_decoder_pkg
//   Shared types and helpers for the ramp decoder (receive side of the 8-bit
//   step counter).
//   - state_t       : tracking FSM states (ACQ, TRAIN, LOCKED)
//   - step_t        : classified step {valid, up, mag}
//   - QW/DW/FW_DEF  : default sample, step and wrap-count widths
//   - classify_step : turns a modular sample difference into a step
// ---------------------------------------------------------------------------
package ramp_decoder_pkg;

    localparam int unsigned QW_DEF = 8;
    localparam int unsigned DW_DEF = 4;
    localparam int unsigned FW_DEF = 20;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        up;
        logic [15:0] mag;
    } step_t;

    // d is (qin - q_prev) mod 2**qw, zero-extended.
    // Small forward distances are up-steps; distances just short of a full
    // turn are down-steps. Zero and the large middle band are invalid.
    function automatic step_t classify_step(input logic [31:0] d,
                                            input int unsigned qw,
                                            input int unsigned dw);
        logic [31:0] max_step;
        logic [31:0] modulus;
        step_t       s;
        max_step = (32'd1 << dw) - 32'd1;
        modulus  = 32'd1 << qw;
        s        = '0;
        if ((d != '0) && (d <= max_step)) begin
            s.valid = 1'b1;
            s.up    = 1'b1;
            s.mag   = d[15:0];
        end else if ((d >= (modulus - max_step)) && (d < modulus)) begin
            s.valid = 1'b1;
            s.up    = 1'b0;
            s.mag   = 16'(modulus - d);
        end
        return s;
    endfunction

endpackage

// File: rtl/ramp_decoder_window_timer.sv
// ---------------------------------------------------------------------------
// window_timer
//   Free-running gate-window counter 0..WINDOW_CYCLES-1, restarted by reset.
//   Ports:
//     clk   in  clock
//     reset in  synchronous active-high reset (counter -> 0)
//     last  out high during the final cycle of each window
// ---------------------------------------------------------------------------
module window_timer #(
    parameter int unsigned WINDOW_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic last
);

    localparam int unsigned CW = $clog2(WINDOW_CYCLES);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WINDOW_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ramp_decoder.sv
// ---------------------------------------------------------------------------
// ramp_decoder
//   Monitors the step counter's output stream: recovers step size and
//   direction, flags preload discontinuities and counts wrap-arounds over a
//   fixed gate window.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     qin          sampled counter value (one per clk)
//     delta_out    recovered step magnitude (valid while locked)
//     up_dn_out    recovered direction, 1 = up (valid while locked)
//     locked       step/direction tracking established
//     preload_det  1-cycle pulse on a step mismatch while locked
//     wrap_count   wraps counted in the last completed window
//     wrap_valid   1-cycle pulse when wrap_count updates
//     err_count    saturating preload_det count
//                  (present only with RAMP_DECODER_ERRCNT_EN defined)
// ---------------------------------------------------------------------------
module ramp_decoder
    import ramp_decoder_pkg::*;
#(
    parameter int unsigned QW            = QW_DEF,
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned FW            = FW_DEF,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned LOCK_COUNT    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [QW-1:0] qin,
    output logic [DW-1:0] delta_out,
    output logic          up_dn_out,
    output logic          locked,
    output logic          preload_det,
    output logic [FW-1:0] wrap_count,
    output logic          wrap_valid
`ifdef RAMP_DECODER_ERRCNT_EN
   ,output logic [15:0]   err_count
`endif
);

    localparam int unsigned    RW      = $clog2(LOCK_COUNT + 1);
    localparam logic [FW-1:0]  ACC_MAX = '1;

    state_t        state, state_n;
    logic [QW-1:0] q_prev;
    logic [QW-1:0] d;
    step_t         cur;
    step_t         cand, cand_n;
    logic [RW-1:0] run, run_n;
    logic          mismatch;
    logic          lock_now;
    logic          wrap_this;
    logic          win_last;
    logic [FW-1:0] acc, acc_sum;

    assign d   = qin - q_prev;
    assign cur = classify_step(32'(d), QW, DW);

    window_timer #(
        .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_window_timer (
        .clk  (clk),
        .reset(reset),
        .last (win_last)
    );

    // ---------------- FSM next state ----------------
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        run_n     = run;
        mismatch  = 1'b0;
        lock_now  = 1'b0;
        wrap_this = 1'b0;
        case (state)
            ACQ: begin
                state_n = TRAIN;
                run_n   = '0;
            end
            TRAIN: begin
                if (!cur.valid) begin
                    run_n = '0;
                end else if ((cur == cand) && (run != '0)) begin
                    run_n = run + RW'(1);
                end else begin
                    cand_n = cur;
                    run_n  = RW'(1);
                end
                if (run_n == RW'(LOCK_COUNT)) begin
                    lock_now = 1'b1;
                    state_n  = LOCKED;
                end
            end
            LOCKED: begin
                // cand is always valid here, so an invalid step never matches.
                if (cur == cand) begin
                    wrap_this = cand.up ? (qin < q_prev) : (qin > q_prev);
                end else begin
                    mismatch = 1'b1;
                    state_n  = TRAIN;
                    run_n    = '0;
                end
            end
            default: begin
                state_n = ACQ;
            end
        endcase
    end

    assign acc_sum = (acc == ACC_MAX) ? ACC_MAX : (acc + FW'(wrap_this));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQ;
        end else begin
            state <= state_n;
        end
    end

    // ---------------- datapath / outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev      <= '0;
            cand        <= '0;
            run         <= '0;
            delta_out   <= '0;
            up_dn_out   <= 1'b0;
            locked      <= 1'b0;
            preload_det <= 1'b0;
            wrap_count  <= '0;
            wrap_valid  <= 1'b0;
            acc         <= '0;
        end else begin
            q_prev      <= qin;
            cand        <= cand_n;
            run         <= run_n;
            preload_det <= mismatch;
            if (lock_now) begin
                locked    <= 1'b1;
                delta_out <= cur.mag[DW-1:0];
                up_dn_out <= cur.up;
            end else if (mismatch) begin
                locked    <= 1'b0;
            end
            // The closing cycle's own wrap is folded into the reported count.
            if (win_last) begin
                wrap_count <= acc_sum;
                wrap_valid <= 1'b1;
                acc        <= '0;
            end else begin
                wrap_valid <= 1'b0;
                acc        <= acc_sum;
            end
        end
    end

`ifdef RAMP_DECODER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (mismatch && (err_count != '1)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ramp_decoder.sv
// ---------------------------------------------------------------------------
// tb_ramp_decoder
//   Drives ramp_decoder with a step-counter model (directed phases followed
//   by randomized phases). A reference model computes the expected response
//   of every clock edge and queues it; a monitor pops and compares after each
//   edge, and on every wrap_valid pulse.
//   Define RAMP_DECODER_ERRCNT_EN to also check err_count.
// ---------------------------------------------------------------------------
module tb_ramp_decoder;

    localparam int QW   = 8;
    localparam int DW   = 4;
    localparam int FW   = 20;
    localparam int WIN  = 1024;
    localparam int LOCK = 4;
    localparam int FMAX = (1 << FW) - 1;
    localparam int SMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [QW-1:0] qin;
    logic [DW-1:0] delta_out;
    logic          up_dn_out;
    logic          locked;
    logic          preload_det;
    logic [FW-1:0] wrap_count;
    logic          wrap_valid;
`ifdef RAMP_DECODER_ERRCNT_EN
    logic [15:0]   err_count;
`endif

    always #5 clk = ~clk;

    ramp_decoder #(
        .QW           (QW),
        .DW           (DW),
        .FW           (FW),
        .WINDOW_CYCLES(WIN),
        .LOCK_COUNT   (LOCK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .qin        (qin),
        .delta_out  (delta_out),
        .up_dn_out  (up_dn_out),
        .locked     (locked),
        .preload_det(preload_det),
        .wrap_count (wrap_count),
        .wrap_valid (wrap_valid)
`ifdef RAMP_DECODER_ERRCNT_EN
       ,.err_count  (err_count)
`endif
    );

    typedef struct {
        int locked;
        int delta;
        int updn;
        int preload;
        int wcnt;
        int err;
    } exp_t;

    typedef struct {
        int edge_no;
        int wcnt;
    } win_t;

    exp_t cyc_q[$];
    win_t win_q[$];

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;
    bit mon_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, mcnt, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Steps are signed codes: +n = up by n, -n = down by n, 0 = not a step.
    int m_edge   = 0;
    bit m_acq    = 1'b1;
    int m_qprev  = 0;
    int hist[$];
    int m_locked = 0;
    int m_code   = 0;
    int m_delta  = 0;
    int m_updn   = 0;
    int m_wpos   = 0;
    int m_acc    = 0;
    int m_wcnt   = 0;
    int m_err    = 0;

    function automatic int step_code(input int q, input int qp);
        int d;
        d = (q - qp) & ((1 << QW) - 1);
        if (d >= 1 && d <= SMAX) return d;
        if (d >= (1 << QW) - SMAX) return -((1 << QW) - d);
        return 0;
    endfunction

    task automatic model_edge(input bit rst, input int q);
        exp_t e;
        win_t w;
        int   c;
        int   n;
        int   wrap;
        int   pl;
        m_edge++;
        pl   = 0;
        wrap = 0;
        if (rst) begin
            m_acq    = 1'b1;
            hist.delete();
            m_locked = 0;
            m_delta  = 0;
            m_updn   = 0;
            m_wpos   = 0;
            m_acc    = 0;
            m_wcnt   = 0;
            m_err    = 0;
        end else begin
            if (m_acq) begin
                m_acq = 1'b0;
            end else begin
                c = step_code(q, m_qprev);
                if (m_locked != 0) begin
                    if (c == m_code) begin
                        wrap = (c > 0) ? int'(q < m_qprev) : int'(q > m_qprev);
                    end else begin
                        pl       = 1;
                        m_locked = 0;
                        hist.delete();
                        if (m_err < 65535) m_err++;
                    end
                end else begin
                    hist.push_back(c);
                    if (hist.size() > LOCK) void'(hist.pop_front());
                    n = 0;
                    for (int i = hist.size() - 1; i >= 0; i--) begin
                        if (hist[i] != c) break;
                        n++;
                    end
                    if (c != 0 && n >= LOCK) begin
                        m_locked = 1;
                        m_code   = c;
                        m_delta  = (c > 0) ? c : -c;
                        m_updn   = (c > 0) ? 1 : 0;
                        hist.delete();
                    end
                end
            end
            m_qprev = q;
            if (m_wpos == WIN - 1) begin
                m_wcnt    = (m_acc + wrap > FMAX) ? FMAX : m_acc + wrap;
                w.edge_no = m_edge;
                w.wcnt    = m_wcnt;
                win_q.push_back(w);
                m_acc  = 0;
                m_wpos = 0;
            end else begin
                m_acc = (m_acc + wrap > FMAX) ? FMAX : m_acc + wrap;
                m_wpos++;
            end
        end
        e.locked  = m_locked;
        e.delta   = m_delta;
        e.updn    = m_updn;
        e.preload = pl;
        e.wcnt    = m_wcnt;
        e.err     = m_err;
        cyc_q.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    int cval = 0;

    task automatic drive(input bit rst, input int q);
        reset = rst;
        qin   = QW'(q);
        model_edge(rst, q & ((1 << QW) - 1));
        @(negedge clk);
    endtask

    task automatic run_counter(input int n, input int delta, input bit up);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, cval);
            cval = (up ? cval + delta : cval - delta) & ((1 << QW) - 1);
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, cval);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, cval);
    endtask

    initial begin
        int kind;
        int len;
        // 1: up by 1 from 0 after reset
        cval = 0;
        do_reset(3);
        run_counter(2100, 1, 1'b1);
        // 2: step changes 1 -> 3 mid-run
        run_counter(2100, 3, 1'b1);
        // 3: down by 4
        run_counter(2100, 4, 1'b0);
        // 4: preload 8'h80 during locked up count
        run_counter(300, 1, 1'b1);
        cval = 8'h80;
        run_counter(300, 1, 1'b1);
        // 5: constant input
        hold(1100);
        // 6: reset mid-window while locked
        run_counter(1500, 2, 1'b1);
        do_reset(2);
        cval = 0;
        run_counter(1100, 1, 1'b1);
        // randomized phases
        for (int p = 0; p < 14; p++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(40, 700));
            case (kind)
                0: do_reset(int'($urandom_range(1, 3)));
                1: begin
                    cval = int'($urandom_range(0, 255));
                    run_counter(len, int'($urandom_range(1, SMAX)), 1'($urandom_range(0, 1)));
                end
                2: for (int i = 0; i < len; i++) drive(1'b0, int'($urandom_range(0, 255)));
                3: hold(len);
                4: run_counter(len, int'($urandom_range(SMAX + 1, 40)), 1'($urandom_range(0, 1)));
                default: run_counter(len, int'($urandom_range(1, SMAX)), 1'($urandom_range(0, 1)));
            endcase
        end
        run_counter(1100, 5, 1'b0);
        mon_en = 1'b0;
        check("cyc_q_drained", cyc_q.size(), 0);
        check("win_q_drained", win_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        win_t w;
        forever begin
            @(posedge clk);
            mcnt++;
            #1;
            if (mon_en) begin
                if (cyc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cyc_q_underflow at edge %0d: got empty queue expected an entry", mcnt);
                end else begin
                    e = cyc_q.pop_front();
                    check("locked", int'(locked), e.locked);
                    check("delta_out", int'(delta_out), e.delta);
                    check("up_dn_out", int'(up_dn_out), e.updn);
                    check("preload_det", int'(preload_det), e.preload);
                    check("wrap_count_hold", int'(wrap_count), e.wcnt);
`ifdef RAMP_DECODER_ERRCNT_EN
                    check("err_count", int'(err_count), e.err);
`endif
                end
                if (wrap_valid) begin
                    if (win_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wrap_valid_spurious at edge %0d: got pulse expected none", mcnt);
                    end else begin
                        w = win_q.pop_front();
                        check("wrap_valid_edge", mcnt, w.edge_no);
                        check("wrap_count", int'(wrap_count), w.wcnt);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

endmodule
